prf_release_int: RTL and testbench

Commit-side release unit for the integer physical register file. It consumes up to RENAME_WIDTH retiring micro-ops per cycle from the ROB and forwards each stale physical register (old_prd) to freelist_int via prf_replace_valid/prf_replace. It also maintains the committed (architectural) busy vector, which drives freelist_int's recover_fl on a pipeline flush. It sits between ROB commit and the rename-stage free list.

---
 rtl/prf_release_int_if.sv | 21 ++
 rtl/prf_release_int.sv | 102 ++++++++++
 tb/tb_prf_release_int.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/prf_release_int_if.sv
// Commit bus between ROB retirement and the integer PRF release unit.
interface prf_release_int_if #(
  parameter int unsigned RENAME_WIDTH   = 4,
  parameter int unsigned PRF_INDEX_SIZE = 6
);
  logic [RENAME_WIDTH-1:0]                     commit_valid;
  logic [RENAME_WIDTH-1:0]                     commit_has_dest;
  logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0] commit_old_prd;
  logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0] commit_new_prd;
  logic                                        commit_ready;

  modport master (
    output commit_valid, commit_has_dest, commit_old_prd, commit_new_prd,
    input  commit_ready
  );

  modport slave (
    input  commit_valid, commit_has_dest, commit_old_prd, commit_new_prd,
    output commit_ready
  );
endinterface

// File: rtl/prf_release_int.sv
// Commit-side release unit: frees stale integer physical registers and tracks
// the committed busy vector used to rebuild the free list on a flush.
module prf_release_int #(
  parameter int unsigned RENAME_WIDTH   = 4,
  parameter int unsigned PRF_SIZE       = 64,
  parameter int unsigned PRF_INDEX_SIZE = 6
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        stall_i,
  input  logic                                        recover_i,
  prf_release_int_if.slave                            commit_if,
  output logic [RENAME_WIDTH-1:0]                     prf_replace_valid_o,
  output logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0] prf_replace_o,
  output logic [PRF_SIZE-1:0]                         recover_fl_o,
  output logic [PRF_INDEX_SIZE:0]                     arch_free_num_o,
  output logic                                        double_free_o
);

  localparam int unsigned FREE_W = PRF_INDEX_SIZE + 1;
  localparam logic [PRF_SIZE-1:0] BUSY_RST = PRF_SIZE'(1);

  logic [PRF_SIZE-1:0]                         busy_q, busy_d;
  logic [FREE_W-1:0]                           free_q, free_d;
  logic                                        df_q, df_d;
  logic [RENAME_WIDTH-1:0]                     rv_q, rv_d;
  logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0] rp_q, rp_d;
  logic [RENAME_WIDTH-1:0]                     accept;
  logic [RENAME_WIDTH-1:0]                     rel_valid;
  logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0] rel_idx;

  assign commit_if.commit_ready = !stall_i && !recover_i;

  // Slot-ordered busy update; later slots overwrite earlier ones on the same index.
  always_comb begin
    busy_d    = busy_q;
    df_d      = df_q;
    rel_valid = '0;
    rel_idx   = '0;
    accept    = commit_if.commit_valid & commit_if.commit_has_dest
              & {RENAME_WIDTH{commit_if.commit_ready}};
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      if (accept[i]) begin
        if (commit_if.commit_old_prd[i] != '0) begin
          rel_valid[i] = 1'b1;
          rel_idx[i]   = commit_if.commit_old_prd[i];
          if (!busy_d[commit_if.commit_old_prd[i]]) begin
            df_d = 1'b1;
          end
          busy_d[commit_if.commit_old_prd[i]] = 1'b0;
        end
        if (commit_if.commit_new_prd[i] != '0) begin
          busy_d[commit_if.commit_new_prd[i]] = 1'b1;
        end
      end
    end
  end

  // Free count is the population of zeros in the next committed vector.
  always_comb begin
    free_d = '0;
    for (int unsigned j = 0; j < PRF_SIZE; j++) begin
      free_d = free_d + FREE_W'(!busy_d[j]);
    end
  end

  // A recover edge drops pending releases: recover_fl already reflects them.
  always_comb begin
    rv_d = rv_q;
    rp_d = rp_q;
    if (recover_i) begin
      rv_d = '0;
      rp_d = '0;
    end else if (!stall_i) begin
      rv_d = rel_valid;
      rp_d = rel_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= BUSY_RST;
      free_q <= FREE_W'(PRF_SIZE - 1);
      df_q   <= 1'b0;
      rv_q   <= '0;
      rp_q   <= '0;
    end else begin
      busy_q <= busy_d;
      free_q <= free_d;
      df_q   <= df_d;
      rv_q   <= rv_d;
      rp_q   <= rp_d;
    end
  end

  assign prf_replace_valid_o = rv_q;
  assign prf_replace_o       = rp_q;
  assign recover_fl_o        = busy_q;
  assign arch_free_num_o     = free_q;
  assign double_free_o       = df_q;

endmodule

// File: tb/tb_prf_release_int.sv
// Bench for prf_release_int: directed vector table, corner sequences and
// randomized traffic checked against a behavioural busy-set model.
module tb_prf_release_int;

  logic              clock = 1'b0;
  logic              reset, stall, recover;
  logic [3:0]        prf_replace_valid;
  logic [3:0][5:0]   prf_replace;
  logic [63:0]       recover_fl;
  logic [6:0]        arch_free_num;
  logic              double_free;

  prf_release_int_if #(.RENAME_WIDTH(4), .PRF_INDEX_SIZE(6)) cif ();

  prf_release_int #(.RENAME_WIDTH(4), .PRF_SIZE(64), .PRF_INDEX_SIZE(6)) dut (
    .clock               (clock),
    .reset               (reset),
    .stall_i             (stall),
    .recover_i           (recover),
    .commit_if           (cif),
    .prf_replace_valid_o (prf_replace_valid),
    .prf_replace_o       (prf_replace),
    .recover_fl_o        (recover_fl),
    .arch_free_num_o     (arch_free_num),
    .double_free_o       (double_free)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the set of committed-busy registers and the pending release lanes.
  bit              m_busy [64];
  bit              m_df;
  logic [3:0]      m_rv;
  logic [3:0][5:0] m_rp;

  typedef struct {
    bit         rst;
    bit         st;
    bit         rc;
    logic [3:0] v;
    logic [23:0] op;
    logic [23:0] np;
    logic [3:0] erv;
    logic [23:0] erp;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t row(bit rst, bit st, bit rc, logic [3:0] v,
                               logic [23:0] op, logic [23:0] np,
                               logic [3:0] erv, logic [23:0] erp);
    vec_t r;
    r.rst = rst; r.st = st; r.rc = rc; r.v = v;
    r.op = op; r.np = np; r.erv = erv; r.erp = erp;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    m_busy[0] = 1'b1;
    m_df = 1'b0;
    m_rv = '0;
    m_rp = '0;
  endtask

  // Applies the edge that just happened, using the inputs held across it.
  task automatic model_edge();
    logic [3:0]      rv_new;
    logic [3:0][5:0] rp_new;
    rv_new = '0;
    rp_new = '0;
    if (reset) begin
      model_reset();
      return;
    end
    if (!stall && !recover) begin
      for (int i = 0; i < 4; i++) begin
        if (cif.commit_valid[i] && cif.commit_has_dest[i]) begin
          if (cif.commit_old_prd[i] != 0) begin
            rv_new[i] = 1'b1;
            rp_new[i] = cif.commit_old_prd[i];
            if (m_busy[cif.commit_old_prd[i]] == 1'b0) m_df = 1'b1;
            m_busy[cif.commit_old_prd[i]] = 1'b0;
          end
          if (cif.commit_new_prd[i] != 0) m_busy[cif.commit_new_prd[i]] = 1'b1;
        end
      end
    end
    if (recover) begin
      m_rv = '0;
      m_rp = '0;
    end else if (!stall) begin
      m_rv = rv_new;
      m_rp = rp_new;
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] fl;
    int          nfree;
    nfree = 0;
    for (int k = 0; k < 64; k++) begin
      fl[k] = m_busy[k];
      if (!m_busy[k]) nfree++;
    end
    check({tag, ".recover_fl"}, recover_fl, fl);
    check({tag, ".arch_free_num"}, 64'(arch_free_num), 64'(nfree));
    check({tag, ".double_free"}, 64'(double_free), 64'(m_df));
    check({tag, ".replace_valid"}, 64'(prf_replace_valid), 64'(m_rv));
    check({tag, ".replace"}, 64'(prf_replace), 64'(m_rp));
  endtask

  task automatic drive(input bit rst, input bit st, input bit rc, input logic [3:0] v,
                       input logic [3:0] hd, input logic [23:0] op, input logic [23:0] np);
    reset               = rst;
    stall               = st;
    recover             = rc;
    cif.commit_valid    = v;
    cif.commit_has_dest = hd;
    cif.commit_old_prd  = op;
    cif.commit_new_prd  = np;
  endtask

  // One clock: check the combinational ready, take the edge, check registered state.
  task automatic tick(input string tag);
    #1;
    check({tag, ".commit_ready"}, 64'(cif.commit_ready), 64'(!stall && !recover));
    @(posedge clock);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    model_reset();
    drive(1, 0, 0, 4'b0, 4'b0, 24'd0, 24'd0);

    tbl[0]  = row(1, 0, 0, 4'b0000, 24'd0, 24'd0, 4'b0000, 24'd0);
    tbl[1]  = row(0, 0, 0, 4'b0001, {18'd0, 6'd5}, {18'd0, 6'd9}, 4'b0001, {18'd0, 6'd5});
    tbl[2]  = row(0, 0, 0, 4'b1111, {6'd12, 6'd0, 6'd7, 6'd0}, {6'd21, 6'd22, 6'd23, 6'd24},
                  4'b1010, {6'd12, 6'd0, 6'd7, 6'd0});
    tbl[3]  = row(0, 0, 0, 4'b0100, {6'd0, 6'd20, 12'd0}, {6'd0, 6'd25, 12'd0},
                  4'b0100, {6'd0, 6'd20, 12'd0});
    tbl[4]  = row(0, 1, 0, 4'b1111, {4{6'd33}}, {4{6'd34}}, 4'b0100, {6'd0, 6'd20, 12'd0});
    tbl[5]  = row(0, 1, 0, 4'b1111, {4{6'd33}}, {4{6'd34}}, 4'b0100, {6'd0, 6'd20, 12'd0});
    tbl[6]  = row(0, 1, 0, 4'b1111, {4{6'd33}}, {4{6'd34}}, 4'b0100, {6'd0, 6'd20, 12'd0});
    tbl[7]  = row(0, 0, 0, 4'b0000, 24'd0, 24'd0, 4'b0000, 24'd0);
    tbl[8]  = row(0, 0, 0, 4'b0001, {18'd0, 6'd30}, {18'd0, 6'd31}, 4'b0001, {18'd0, 6'd30});
    tbl[9]  = row(0, 0, 1, 4'b0001, {18'd0, 6'd35}, {18'd0, 6'd36}, 4'b0000, 24'd0);
    tbl[10] = row(0, 0, 0, 4'b0000, 24'd0, 24'd0, 4'b0000, 24'd0);

    for (int r = 0; r < 11; r++) begin
      drive(tbl[r].rst, tbl[r].st, tbl[r].rc, tbl[r].v, tbl[r].v, tbl[r].op, tbl[r].np);
      tick($sformatf("row%0d", r));
      check($sformatf("row%0d.tbl_valid", r), 64'(prf_replace_valid), 64'(tbl[r].erv));
      check($sformatf("row%0d.tbl_replace", r), 64'(prf_replace), 64'(tbl[r].erp));
      if (r == 0) check("row0.arch_free_63", 64'(arch_free_num), 64'd63);
      if (r == 1) begin
        check("row1.fl5", 64'(recover_fl[5]), 64'd0);
        check("row1.fl9", 64'(recover_fl[9]), 64'd1);
      end
      if (r == 2) check("row2.p0_busy", 64'(recover_fl[0]), 64'd1);
      if (r == 6) check("row6.no_commit_34", 64'(recover_fl[34]), 64'd0);
      if (r == 9) check("row9.fl30", 64'(recover_fl[30]), 64'd0);
    end

    // Double free: make 40 busy, free it once cleanly, then free it again.
    drive(1, 0, 0, 4'b0, 4'b0, 24'd0, 24'd0);
    tick("df.rst");
    drive(0, 0, 0, 4'b0001, 4'b0001, {18'd0, 6'd0}, {18'd0, 6'd40});
    tick("df.set40");
    drive(0, 0, 0, 4'b0001, 4'b0001, {18'd0, 6'd40}, {18'd0, 6'd42});
    tick("df.free1");
    check("df.after_first", 64'(double_free), 64'd0);
    drive(0, 0, 0, 4'b0001, 4'b0001, {18'd0, 6'd40}, {18'd0, 6'd43});
    tick("df.free2");
    check("df.after_second", 64'(double_free), 64'd1);
    drive(0, 0, 1, 4'b0, 4'b0, 24'd0, 24'd0);
    tick("df.recover");
    drive(0, 0, 0, 4'b0, 4'b0, 24'd0, 24'd0);
    tick("df.idle");
    check("df.sticky", 64'(double_free), 64'd1);
    drive(1, 0, 0, 4'b0, 4'b0, 24'd0, 24'd0);
    tick("df.rst2");
    check("df.cleared", 64'(double_free), 64'd0);

    // Same-cycle collision on p15 in both slot orders.
    drive(0, 0, 0, 4'b0011, 4'b0011, {12'd0, 6'd15, 6'd0}, {12'd0, 6'd16, 6'd15});
    tick("col.set_then_free");
    check("col.fl15_free", 64'(recover_fl[15]), 64'd0);
    drive(0, 0, 0, 4'b0011, 4'b0011, {12'd0, 6'd0, 6'd15}, {12'd0, 6'd15, 6'd50});
    tick("col.free_then_set");
    check("col.fl15_busy", 64'(recover_fl[15]), 64'd1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom),
            24'($urandom), 24'($urandom));
      tick($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
